wptr_full_prog: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO, successor to the fixed-threshold write-pointer block. Lives in the `wclk` domain. Generates the binary write address and the Gray write pointer for the read-side synchronizer. From the already-synchronized Gray read pointer it derives full, a run-time programmable almost-full with hysteresis, a registered fill level and sticky overflow detection.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/gray_to_bin.sv | 13 +
 rtl/wptr_full_prog.sv | 158 +++++++++++++++
 tb/tb_wptr_full_prog.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared Gray helpers, counter width and almost-full states for the async FIFO
package fifo_pkg;

  localparam int OVF_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    AF   = 1'b1
  } af_state_t;

  function automatic logic [31:0] width_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
    logic [31:0] v;
    v = b & width_mask(w);
    return v ^ (v >> 1);
  endfunction

  // Prefix XOR from the MSB down; bits above w are forced to zero first.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] v;
    v = g & width_mask(w);
    for (int s = 1; s < 32; s = s * 2) begin
      v = v ^ (v >> s);
    end
    return v;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray to binary converter of width SIZE
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] i_gray,
  output logic [SIZE-1:0] o_bin
);

  assign o_bin = SIZE'(gray2bin(32'(i_gray), SIZE));

endmodule

// File: rtl/wptr_full_prog.sv
// rtl/wptr_full_prog.sv - write pointer, full/almost-full/level/overflow logic; WPTR_OVF_CNT_EN builds the drop counter
module wptr_full_prog
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = 6,
  parameter int AF_THRESH_DEF = 62,
  parameter int AF_HYST       = 0
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDRSIZE:0]     wq2_rptr,
  input  logic [ADDRSIZE:0]     af_thresh_in,
  input  logic                  af_thresh_ld,
  input  logic                  wovf_clr,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic [ADDRSIZE:0]     wptr,
  output logic [ADDRSIZE:0]     wbin,
  output logic                  wfull,
  output logic                  almost_full,
  output logic [ADDRSIZE:0]     wlevel,
  output logic                  wovf,
  output logic [OVF_CNT_W-1:0]  wovf_cnt
);

  localparam int PW      = ADDRSIZE + 1;
  localparam int DEPTH   = 1 << ADDRSIZE;
  localparam int THR_R_I = (AF_THRESH_DEF <= 0) ? 1 :
                           (AF_THRESH_DEF > DEPTH) ? DEPTH : AF_THRESH_DEF;
  localparam int HYST_I  = (AF_HYST < 0) ? 0 : (AF_HYST > DEPTH) ? DEPTH : AF_HYST;

  localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
  localparam logic [PW-1:0] THR_RST = PW'(THR_R_I);
  localparam logic [PW-1:0] HYST_V  = PW'(HYST_I);
  localparam logic [PW-1:0] ONE_V   = PW'(1);

  function automatic logic [PW-1:0] clamp_thr(input logic [PW-1:0] x);
    if (x == '0) return ONE_V;
    if (x > DEPTH_V) return DEPTH_V;
    return x;
  endfunction

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_wlevel;
  logic          r_wfull;
  logic          r_wovf;
  logic [PW-1:0] r_thr;
  af_state_t     r_af_state;

  logic          w_wacc;
  logic          w_drop;
  logic [PW-1:0] w_wbinnext;
  logic [PW-1:0] w_wgraynext;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] w_lo;
  af_state_t     w_af_next;

  assign w_wacc      = winc & ~r_wfull;
  assign w_drop      = winc & r_wfull;
  assign w_wbinnext  = r_wbin + {{(PW-1){1'b0}}, w_wacc};
  assign w_wgraynext = PW'(bin2gray(32'(w_wbinnext), PW));

  gray_to_bin #(
    .SIZE (PW)
  ) u_rptr_g2b (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin)
  );

  // Modulo-2^PW subtraction keeps the level right across pointer wrap.
  assign w_level_next = w_wbinnext - w_rbin;
  assign w_lo         = (r_thr > HYST_V) ? (r_thr - HYST_V) : ONE_V;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wlevel <= '0;
      r_wfull  <= 1'b0;
    end else begin
      r_wbin   <= w_wbinnext;
      r_wptr   <= w_wgraynext;
      r_wlevel <= w_level_next;
      r_wfull  <= (w_level_next == DEPTH_V);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_thr <= THR_RST;
    end else if (af_thresh_ld) begin
      r_thr <= clamp_thr(af_thresh_in);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wovf <= 1'b0;
    end else if (w_drop) begin
      r_wovf <= 1'b1;
    end else if (wovf_clr) begin
      r_wovf <= 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_af_state <= IDLE;
    end else begin
      r_af_state <= w_af_next;
    end
  end

  // Full implies level >= thr (thr <= DEPTH), so AF is held while full.
  always_comb begin
    w_af_next = r_af_state;
    case (r_af_state)
      IDLE:    if (w_level_next >= r_thr) w_af_next = AF;
      AF:      if (w_level_next < w_lo)   w_af_next = IDLE;
      default: w_af_next = IDLE;
    endcase
  end

  always_comb begin
    almost_full = (r_af_state == AF);
  end

`ifdef WPTR_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] r_wovf_cnt;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wovf_cnt <= '0;
    end else if (w_drop) begin
      if (wovf_clr)
        r_wovf_cnt <= OVF_CNT_W'(1);
      else if (r_wovf_cnt != {OVF_CNT_W{1'b1}})
        r_wovf_cnt <= r_wovf_cnt + OVF_CNT_W'(1);
    end else if (wovf_clr) begin
      r_wovf_cnt <= '0;
    end
  end

  assign wovf_cnt = r_wovf_cnt;
`else
  assign wovf_cnt = '0;
`endif

  assign waddr  = r_wbin[ADDRSIZE-1:0];
  assign wbin   = r_wbin;
  assign wptr   = r_wptr;
  assign wlevel = r_wlevel;
  assign wfull  = r_wfull;
  assign wovf   = r_wovf;

endmodule

// File: tb/tb_wptr_full_prog.sv
// tb/tb_wptr_full_prog.sv - directed self-checking bench for wptr_full_prog (DEPTH 8, thr 6, hyst 2)
module tb_wptr_full_prog;

`ifdef WPTR_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        wclk;
  logic        wrst_n;
  logic        winc;
  logic [3:0]  wq2_rptr;
  logic [3:0]  af_thresh_in;
  logic        af_thresh_ld;
  logic        wovf_clr;
  logic [2:0]  waddr;
  logic [3:0]  wptr;
  logic [3:0]  wbin;
  logic        wfull;
  logic        almost_full;
  logic [3:0]  wlevel;
  logic        wovf;
  logic [15:0] wovf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  wptr_full_prog #(
    .ADDRSIZE      (3),
    .AF_THRESH_DEF (6),
    .AF_HYST       (2)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .af_thresh_in (af_thresh_in),
    .af_thresh_ld (af_thresh_ld),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wbin         (wbin),
    .wfull        (wfull),
    .almost_full  (almost_full),
    .wlevel       (wlevel),
    .wovf         (wovf),
    .wovf_cnt     (wovf_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0;
    af_thresh_in = '0; af_thresh_ld = 1'b0; wovf_clr = 1'b0;
    tick(); tick();
    wrst_n = 1'b1;
  endtask

  task automatic load_thr(input logic [3:0] t);
    af_thresh_in = t; af_thresh_ld = 1'b1;
    tick();
    af_thresh_ld = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_wbin", wbin, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_wovf", wovf, 0);
    chk("rst_cnt", wovf_cnt, 0);

    // Fill to full with rptr held at 0
    for (int i = 1; i <= 8; i++) begin
      winc = 1'b1;
      tick();
      chk("fill_level", wlevel, i);
      if (i == 5) chk("fill_af5", almost_full, 0);
      if (i == 6) chk("fill_af6", almost_full, 1);
      if (i == 7) chk("fill_full7", wfull, 0);
    end
    chk("fill_full", wfull, 1);
    chk("fill_wbin", wbin, 8);
    chk("fill_wptr", wptr, 4'b1100);
    chk("fill_waddr", waddr, 0);
    tick();
    winc = 1'b0;
    chk("drop_wbin", wbin, 8);
    chk("drop_wovf", wovf, 1);
    chk("drop_cnt", wovf_cnt, CNT_EN ? 1 : 0);

    // Drop and clear in the same cycle: set wins, counter restarts at 1
    winc = 1'b1; wovf_clr = 1'b1;
    tick();
    winc = 1'b0; wovf_clr = 1'b0;
    chk("coll_wovf", wovf, 1);
    chk("coll_cnt", wovf_cnt, CNT_EN ? 1 : 0);
    wovf_clr = 1'b1;
    tick();
    wovf_clr = 1'b0;
    chk("clr_wovf", wovf, 0);
    chk("clr_cnt", wovf_cnt, 0);

    // Wrap: read pointer trails two entries behind
    do_reset();
    for (int k = 0; k < 20; k++) begin
      wq2_rptr = gray((k >= 2) ? (k - 2) : 0);
      winc = 1'b1;
      tick();
      chk("wrap_level", wlevel, (k == 0) ? 1 : (k == 1) ? 2 : 3);
      chk("wrap_full", wfull, 0);
    end
    winc = 1'b0;
    chk("wrap_wbin", wbin, 4);
    chk("wrap_wptr", wptr, 4'b0110);
    chk("wrap_waddr", waddr, 4);
    chk("wrap_af", almost_full, 0);

    // Hysteresis: thr 5, low mark 3
    do_reset();
    load_thr(4'd5);
    for (int i = 1; i <= 5; i++) begin
      winc = 1'b1;
      tick();
      if (i == 4) chk("hys_af4", almost_full, 0);
    end
    winc = 1'b0;
    chk("hys_af5", almost_full, 1);
    wq2_rptr = gray(2);
    tick();
    chk("hys_lvl3", wlevel, 3);
    chk("hys_af3", almost_full, 1);
    wq2_rptr = gray(3);
    tick();
    chk("hys_lvl2", wlevel, 2);
    chk("hys_af2", almost_full, 0);

    // Clamp: 0 -> 1, 12 -> 8
    do_reset();
    load_thr(4'd0);
    chk("clamp0_af_pre", almost_full, 0);
    winc = 1'b1;
    tick();
    winc = 1'b0;
    chk("clamp0_af", almost_full, 1);
    load_thr(4'd12);
    tick();
    chk("clamp12_af_drop", almost_full, 0);
    for (int i = 2; i <= 7; i++) begin
      winc = 1'b1;
      tick();
    end
    chk("clamp12_af7", almost_full, 0);
    chk("clamp12_full7", wfull, 0);
    tick();
    winc = 1'b0;
    chk("clamp12_af8", almost_full, 1);
    chk("clamp12_full8", wfull, 1);

    // Async reset mid-burst at level 5 with thr 3
    do_reset();
    load_thr(4'd3);
    for (int i = 1; i <= 5; i++) begin
      winc = 1'b1;
      tick();
    end
    chk("mid_af_pre", almost_full, 1);
    #3;
    wrst_n = 1'b0;
    #1;
    chk("mid_wbin", wbin, 0);
    chk("mid_wptr", wptr, 0);
    chk("mid_wlevel", wlevel, 0);
    chk("mid_wfull", wfull, 0);
    chk("mid_af", almost_full, 0);
    chk("mid_waddr", waddr, 0);
    winc = 1'b0;
    tick();
    wrst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      winc = 1'b1;
      tick();
      if (i == 5) chk("mid_thr_af5", almost_full, 0);
    end
    winc = 1'b0;
    chk("mid_thr_af6", almost_full, 1);

    // Saturation: 70000 drops while full
    do_reset();
    winc = 1'b1;
    repeat (8) tick();
    repeat (70000) tick();
    winc = 1'b0;
    chk("sat_cnt", wovf_cnt, CNT_EN ? 32'hFFFF : 0);
    chk("sat_wovf", wovf, 1);
    chk("sat_wbin", wbin, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
